// File: rtl/ip_checksum_insert_if.sv
// ip_checksum_insert_if: AXI4-Stream bundle (data, strobes, sideband, handshake) for the checksum inserter.
interface ip_checksum_insert_if #(
    parameter int DATA_WIDTH  = 256,
    parameter int TUSER_WIDTH = 128
);
    logic [DATA_WIDTH-1:0]   tdata;
    logic [DATA_WIDTH/8-1:0] tstrb;
    logic [TUSER_WIDTH-1:0]  tuser;
    logic                    tvalid;
    logic                    tready;
    logic                    tlast;
    modport master (output tdata, tstrb, tuser, tvalid, tlast, input tready);
    modport slave  (input tdata, tstrb, tuser, tvalid, tlast, output tready);
endinterface

// File: rtl/ip_checksum_insert.sv
// ip_checksum_insert: rewrites the IPv4 header checksum (beat 0 bytes 24-25) of IHL=5 packets on a 256-bit
// AXI stream; beat 0 is held until beat 1 supplies the last header word, everything else passes unchanged.
module ip_checksum_insert #(
    parameter int C_M_AXIS_DATA_WIDTH  = 256,
    parameter int C_S_AXIS_DATA_WIDTH  = 256,
    parameter int C_M_AXIS_TUSER_WIDTH = 128,
    parameter int C_S_AXIS_TUSER_WIDTH = 128
) (
    input  logic                 AXI_ACLK,
    input  logic                 AXI_RESET,
    ip_checksum_insert_if.slave  s_axis,
    ip_checksum_insert_if.master m_axis,
    output logic [31:0]          csum_rewrite_cnt,
    output logic [31:0]          csum_bypass_cnt,
    output logic [15:0]          last_csum
);
    typedef enum logic [1:0] {IDLE, HOLD, FWD, FLUSH} state_t;
    state_t state, state_nxt;
    logic [C_S_AXIS_DATA_WIDTH-1:0]   h_data;
    logic [C_S_AXIS_DATA_WIDTH/8-1:0] h_strb;
    logic [C_S_AXIS_TUSER_WIDTH-1:0]  h_user;
    logic                             h_last, h_elig;
    logic [19:0]                      h_partial, partial, sum;
    logic [16:0]                      f1;
    logic [15:0]                      f2, csum;
    logic [C_M_AXIS_DATA_WIDTH-1:0]   o_data;
    logic [C_M_AXIS_DATA_WIDTH/8-1:0] o_strb;
    logic [C_M_AXIS_TUSER_WIDTH-1:0]  o_user;
    logic                             o_last, out_free, acc, sop_elig, ld_out, ld_h, cnt_rw, cnt_bp;

    assign out_free      = !m_axis.tvalid || m_axis.tready;
    assign s_axis.tready = out_free && state != FLUSH;
    assign acc           = s_axis.tvalid && s_axis.tready;
    assign sop_elig      = s_axis.tdata[159:144] == 16'h0800 && s_axis.tdata[143:136] == 8'h45 && !s_axis.tlast;

    // header words in beat 0 (bytes 14..31), checksum field excluded
    always_comb begin
        partial = '0;
        for (int i = 0; i < 9; i++)
            if (i != 3) partial = partial + 20'(s_axis.tdata[16*i +: 16]);
    end

    assign sum  = h_partial + 20'(s_axis.tdata[255:240]);
    assign f1   = 17'(sum[15:0]) + 17'(sum[19:16]);
    assign f2   = f1[15:0] + 16'(f1[16]);
    assign csum = ~f2;

    always_comb begin
        state_nxt = state;
        ld_out    = 1'b0;
        ld_h      = 1'b0;
        cnt_rw    = 1'b0;
        cnt_bp    = 1'b0;
        o_data    = h_data;
        o_strb    = h_strb;
        o_user    = h_user;
        o_last    = h_last;
        case (state)
            IDLE: if (acc) begin
                if (s_axis.tlast) begin
                    ld_out = 1'b1;
                    cnt_bp = 1'b1;
                    o_data = s_axis.tdata;
                    o_strb = s_axis.tstrb;
                    o_user = s_axis.tuser;
                    o_last = 1'b1;
                end else begin
                    ld_h      = 1'b1;
                    state_nxt = HOLD;
                end
            end
            HOLD: if (acc) begin
                ld_out    = 1'b1;
                ld_h      = 1'b1;
                cnt_rw    = h_elig;
                cnt_bp    = !h_elig;
                o_data    = h_elig ? {h_data[255:64], csum, h_data[47:0]} : h_data;
                state_nxt = s_axis.tlast ? FLUSH : FWD;
            end
            FWD: if (acc) begin
                ld_out    = 1'b1;
                ld_h      = 1'b1;
                state_nxt = s_axis.tlast ? FLUSH : FWD;
            end
            default: if (out_free) begin
                ld_out    = 1'b1;
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge AXI_ACLK or posedge AXI_RESET) begin
        if (AXI_RESET) begin
            state            <= IDLE;
            m_axis.tvalid    <= 1'b0;
            m_axis.tdata     <= '0;
            m_axis.tstrb     <= '0;
            m_axis.tuser     <= '0;
            m_axis.tlast     <= 1'b0;
            h_data           <= '0;
            h_strb           <= '0;
            h_user           <= '0;
            h_last           <= 1'b0;
            h_elig           <= 1'b0;
            h_partial        <= '0;
            csum_rewrite_cnt <= '0;
            csum_bypass_cnt  <= '0;
            last_csum        <= '0;
        end else begin
            state <= state_nxt;
            if (ld_out) begin
                m_axis.tvalid <= 1'b1;
                m_axis.tdata  <= o_data;
                m_axis.tstrb  <= o_strb;
                m_axis.tuser  <= o_user;
                m_axis.tlast  <= o_last;
            end else if (m_axis.tready) begin
                m_axis.tvalid <= 1'b0;
            end
            // eligibility/partial only matter when the held beat is a SOP
            if (ld_h) begin
                h_data    <= s_axis.tdata;
                h_strb    <= s_axis.tstrb;
                h_user    <= s_axis.tuser;
                h_last    <= s_axis.tlast;
                h_elig    <= sop_elig;
                h_partial <= partial;
            end
            if (cnt_rw) begin
                csum_rewrite_cnt <= csum_rewrite_cnt + 32'd1;
                last_csum        <= csum;
            end
            if (cnt_bp) csum_bypass_cnt <= csum_bypass_cnt + 32'd1;
        end
    end
endmodule

// File: tb/tb_ip_checksum_insert.sv
// tb_ip_checksum_insert: random and directed packets checked by a byte-level checksum model through a
// scoreboard queue; a negedge monitor pops expected beats on each output handshake.
module tb_ip_checksum_insert;
    typedef struct {
        logic [255:0] d;
        logic [31:0]  s;
        logic [127:0] u;
        logic         l;
    } beat_t;

    logic AXI_ACLK  = 1'b0;
    logic AXI_RESET = 1'b0;
    always #5 AXI_ACLK = ~AXI_ACLK;

    ip_checksum_insert_if s_if ();
    ip_checksum_insert_if m_if ();
    logic [31:0] rw_cnt, bp_cnt;
    logic [15:0] lcsum;

    ip_checksum_insert dut (
        .AXI_ACLK         (AXI_ACLK),
        .AXI_RESET        (AXI_RESET),
        .s_axis           (s_if),
        .m_axis           (m_if),
        .csum_rewrite_cnt (rw_cnt),
        .csum_bypass_cnt  (bp_cnt),
        .last_csum        (lcsum)
    );

    int checks = 0, passes = 0;
    beat_t exp_q[$];
    int exp_rw = 0, exp_bp = 0;
    logic [15:0] exp_last = '0;
    int rdy_mode = 0;
    logic [255:0] pd[8];
    logic [31:0]  ps[8];
    logic [127:0] pu[8];
    int pn;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [7:0] get_byte(input int k);
        return pd[k/32][255-8*(k%32) -: 8];
    endfunction

    task automatic set_word(input int k, input logic [15:0] w);
        pd[k/32][255-8*(k%32) -: 8] = w[15:8];
        pd[(k+1)/32][255-8*((k+1)%32) -: 8] = w[7:0];
    endtask

    task automatic rand_pkt(input int n, input logic [15:0] et, input logic [7:0] b14);
        pn = n;
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < 8; j++) pd[i][32*j +: 32] = $urandom();
            ps[i] = $urandom();
            for (int j = 0; j < 4; j++) pu[i][32*j +: 32] = $urandom();
        end
        set_word(12, et);
        pd[0][255-8*14 -: 8] = b14;
    endtask

    task automatic hdr_pkt(input logic [15:0] w[10]);
        pn = 2;
        for (int i = 0; i < 2; i++) begin
            pd[i] = '0;
            ps[i] = '1;
            pu[i] = 128'(i + 7);
        end
        set_word(12, 16'h0800);
        for (int i = 0; i < 10; i++) set_word(14 + 2 * i, w[i]);
    endtask

    task automatic send(input logic [255:0] d, input logic [31:0] st, input logic [127:0] u, input logic l);
        int n = 0;
        s_if.tdata  = d;
        s_if.tstrb  = st;
        s_if.tuser  = u;
        s_if.tlast  = l;
        s_if.tvalid = 1'b1;
        @(negedge AXI_ACLK);
        while (!s_if.tready && n < 2000) begin
            n++;
            @(negedge AXI_ACLK);
        end
        if (!s_if.tready) begin
            checks++;
            $display("FAIL send_timeout: tready stayed %b, required 1", s_if.tready);
        end
        @(posedge AXI_ACLK);
        #1 s_if.tvalid = 1'b0;
    endtask

    // Reference: one's-complement sum over the 20 header bytes (checksum field as zero), byte-addressed.
    task automatic run_pkt(input bit track, input int gap_max);
        beat_t e;
        int s;
        bit elig;
        logic [15:0] cs;
        elig = pn > 1 && get_byte(12) == 8'h08 && get_byte(13) == 8'h00 && get_byte(14) == 8'h45;
        s = 0;
        for (int i = 0; i < 10; i++)
            if (i != 5) s += int'({get_byte(14 + 2 * i), get_byte(15 + 2 * i)});
        while ((s >> 16) != 0) s = (s & 32'hffff) + (s >> 16);
        cs = ~s[15:0];
        if (track) begin
            for (int i = 0; i < pn; i++) begin
                e.d = pd[i];
                if (i == 0 && elig) e.d[255-8*24 -: 16] = cs;
                e.s = ps[i];
                e.u = pu[i];
                e.l = (i == pn - 1);
                exp_q.push_back(e);
            end
            if (elig) begin
                exp_rw++;
                exp_last = cs;
            end else exp_bp++;
        end
        for (int i = 0; i < pn; i++) begin
            repeat ($urandom_range(0, gap_max)) begin
                @(posedge AXI_ACLK);
                #1;
            end
            send(pd[i], ps[i], pu[i], i == pn - 1);
        end
    endtask

    task automatic drain_and_count(input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < 5000) begin
            @(posedge AXI_ACLK);
            n++;
        end
        @(posedge AXI_ACLK);
        #1;
        chk({tag, "_drained"}, exp_q.size(), 0);
        chk({tag, "_rewrite_cnt"}, rw_cnt, exp_rw);
        chk({tag, "_bypass_cnt"}, bp_cnt, exp_bp);
        chk({tag, "_last_csum"}, lcsum, exp_last);
    endtask

    always @(posedge AXI_ACLK) begin
        #1 m_if.tready = rdy_mode == 2 ? 1'($urandom_range(0, 1)) : rdy_mode == 1;
    end

    logic         stall_prev = 1'b0;
    logic [255:0] snap_d;
    logic [161:0] snap_m;
    always @(negedge AXI_ACLK) begin
        beat_t e;
        if (AXI_RESET) stall_prev = 1'b0;
        else begin
            if (stall_prev) begin
                chk("stall_data", m_if.tdata, snap_d);
                chk("stall_ctrl", {m_if.tvalid, m_if.tlast, m_if.tuser, m_if.tstrb}, snap_m);
            end
            if (m_if.tvalid && m_if.tready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_beat: got data %h with empty scoreboard", m_if.tdata);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat_data", m_if.tdata, e.d);
                    chk("beat_side", {m_if.tlast, m_if.tuser, m_if.tstrb}, {e.l, e.u, e.s});
                end
            end
            stall_prev = m_if.tvalid && !m_if.tready;
            snap_d     = m_if.tdata;
            snap_m     = {m_if.tvalid, m_if.tlast, m_if.tuser, m_if.tstrb};
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", passes, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] w[10];
        time t0, t1;
        s_if.tvalid = 1'b0;
        s_if.tdata  = '0;
        s_if.tstrb  = '0;
        s_if.tuser  = '0;
        s_if.tlast  = 1'b0;
        m_if.tready = 1'b0;
        #1 AXI_RESET = 1'b1;
        repeat (3) @(posedge AXI_ACLK);
        #1;
        chk("rst_tvalid", m_if.tvalid, 0);
        chk("rst_tdata", m_if.tdata, 0);
        chk("rst_ctrl", {m_if.tlast, m_if.tuser, m_if.tstrb}, 0);
        chk("rst_counters", {rw_cnt, bp_cnt, lcsum}, 0);
        #2 AXI_RESET = 1'b0;
        @(posedge AXI_ACLK);
        #1 rdy_mode = 1;

        w = '{16'h4500, 16'h0073, 16'h0000, 16'h4000, 16'h4011, 16'hABCD, 16'hc0a8, 16'h0001, 16'hc0a8, 16'h00c7};
        hdr_pkt(w);
        run_pkt(1, 0);
        drain_and_count("ipv4_known");
        chk("ipv4_known_csum", lcsum, 16'hB861);

        rand_pkt(3, 16'h0806, 8'h45);
        run_pkt(1, 1);
        drain_and_count("arp");

        w = '{16'h4500, 16'h0, 16'h0, 16'h0, 16'h0, 16'h1234, 16'h0, 16'h0, 16'h0, 16'hBAFF};
        hdr_pkt(w);
        run_pkt(1, 0);
        drain_and_count("sum_ffff");
        chk("sum_ffff_csum", lcsum, 16'h0000);

        w = '{16'h4500, 16'hFFFF, 16'hFFFF, 16'hBB00, 16'h0, 16'h5555, 16'h0, 16'h0, 16'h0, 16'h0};
        hdr_pkt(w);
        run_pkt(1, 0);
        drain_and_count("double_fold");

        rand_pkt(1, 16'h0800, 8'h45);
        run_pkt(1, 0);
        drain_and_count("single_beat");

        // back-to-back 64B packets: 3 cycles each (two beats plus one boundary bubble)
        t0 = $time;
        for (int k = 0; k < 20; k++) begin
            rand_pkt(2, 16'h0800, 8'h45);
            run_pkt(1, 0);
        end
        t1 = $time;
        chk("b2b_cycles", 256'(t1 - t0), 256'((3 * 20 - 1) * 10));
        drain_and_count("b2b");

        rdy_mode = 2;
        for (int k = 0; k < 100; k++) begin
            rand_pkt($urandom_range(1, 4), $urandom_range(0, 3) == 3 ? 16'h8100 : ($urandom_range(0, 2) == 0 ? 16'h0806 : 16'h0800),
                     $urandom_range(0, 3) == 0 ? 8'h46 : 8'h45);
            run_pkt(1, 1);
        end
        drain_and_count("random");

        rdy_mode = 0;
        repeat (2) @(posedge AXI_ACLK);
        #1;
        rand_pkt(4, 16'h0800, 8'h45);
        send(pd[0], ps[0], pu[0], 1'b0);
        send(pd[1], ps[1], pu[1], 1'b0);
        chk("midpkt_tvalid", m_if.tvalid, 1);
        #2 AXI_RESET = 1'b1;
        #1;
        chk("midrst_tvalid", m_if.tvalid, 0);
        chk("midrst_counters", {rw_cnt, bp_cnt, lcsum}, 0);
        exp_rw   = 0;
        exp_bp   = 0;
        exp_last = '0;
        repeat (2) @(posedge AXI_ACLK);
        #3 AXI_RESET = 1'b0;
        @(posedge AXI_ACLK);
        #1 rdy_mode = 2;
        for (int k = 0; k < 5; k++) begin
            rand_pkt(2 + k % 2, 16'h0800, 8'h45);
            run_pkt(1, 1);
        end
        drain_and_count("after_reset");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
